add_sub_arbiter: RTL and testbench
==================================

ADD_SUB_ARBITER -- requirements
Module: add_sub_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  one-hot grant; request accepted when valid&ready.
REQ-007 req_a  input  NUM_REQ*WIDTH  packed signed first operands, requester k at bits [k*WIDTH +: WIDTH].
REQ-008 req_b  input  NUM_REQ*WIDTH  packed signed second operands, same packing.
REQ-009 req_sub  input  NUM_REQ  1 = a-b, 0 = a+b.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result when rsp_valid&rsp_ready.
REQ-012 rsp_id  output  clog2(NUM_REQ)  index of requester owning the result.
REQ-013 rsp_o  output  WIDTH  signed sum/difference.
REQ-014 rsp_overflow, rsp_zero  output  1 each  signed overflow; result equals zero.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight at a time.
REQ-016 In IDLE, req_ready SHALL be asserted combinationally for exactly one requester, chosen round-robin among asserted req_valid; all req_ready low when no req_valid or not IDLE.
REQ-017 Round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates only on handshake; reset value NUM_REQ-1 (requester 0 has priority first).
REQ-018 On handshake, a, b, sub and requester index SHALL be registered; FSM enters EXEC.
REQ-019 In EXEC the shared adder computes from registered operands; o, overflow, zero registered into rsp_* at end of EXEC; FSM enters RESP.
REQ-020 Latency: handshake in cycle N -> rsp_valid high in cycle N+2.
REQ-021 In RESP, rsp_valid high; rsp_* held stable until rsp_ready sampled high; then FSM returns to IDLE, rsp_valid low next cycle.
REQ-022 New grant SHALL not occur in the cycle rsp handshake completes (no bypass); minimum issue interval 3 cycles.
REQ-023 Arithmetic mod 2^WIDTH; subtraction as a + ~b + 1.
REQ-024 rsp_overflow = operands (b inverted for sub) same sign and result sign differs.
REQ-025 rsp_zero = (rsp_o == 0), independent of overflow.
REQ-026 Requester dropping req_valid before grant is not served; no memory of past requests.

Reset
REQ-027 On rst: FSM IDLE, rsp_valid 0, rsp_o 0, rsp_id 0, rsp_overflow 0, rsp_zero 0, last_grant NUM_REQ-1, req_ready all 0 during rst cycle.
REQ-028 rst in EXEC or RESP SHALL discard in-flight operation; no response produced.
REQ-029 rst overrides simultaneous handshakes on both sides.

Structure
REQ-030 Shared package add_sub_arb_pkg SHALL hold FSM state enum (IDLE, EXEC, RESP) and default WIDTH/NUM_REQ constants.
REQ-031 One sub-module: existing adder (WIDTH, invert_i_2 driven by registered sub), sole arithmetic resource.
REQ-032 Round-robin pick SHALL be a function or always_comb block in this module, not a separate module.

Verification
REQ-033 Single sub: req0 a=15, b=39, sub=1 -> rsp_o=-24, overflow 0, zero 0, rsp_id 0, rsp_valid at N+2.
REQ-034 Overflow: a=32'h7FFFFFFF, b=1, add -> rsp_o=32'h80000000, overflow 1; a=32'h80000000, b=1, sub -> 32'h7FFFFFFF, overflow 1.
REQ-035 Zero: a=210, b=210, sub -> rsp_o 0, zero 1; a=1, b=0, sub -> 1, zero 0.
REQ-036 Fairness: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each issue 3 cycles apart.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, no req_ready asserted; release -> IDLE next cycle.
REQ-038 Reset mid-op: rst in EXEC -> no rsp_valid afterwards, next grant goes to requester 0.

Source files
------------

// File: rtl/add_sub_arb_pkg.sv
// Shared types and default sizing for the add/sub arbiter slice.
package add_sub_arb_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/add_sub_arbiter_adder.sv
// Shared signed adder/subtractor: sum = a + (b or ~b) + invert_i_2,
// with signed overflow and zero flags.
module add_sub_arbiter_adder
  import add_sub_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert_i_2,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] b_eff;

  // Two's-complement subtract folds into the add via inverted b and carry-in.
  always_comb begin
    b_eff    = invert_i_2 ? ~b : b;
    sum      = a + b_eff + {{(WIDTH-1){1'b0}}, invert_i_2};
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    zero     = (sum == '0);
  end

endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter in front of one shared add/sub unit.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester combinationally
// EXEC  | registered operands flow through the shared adder
// RESP  | result held on rsp_* until rsp_ready is seen
module add_sub_arbiter
  import add_sub_arb_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_o,
  output logic                     rsp_overflow,
  output logic                     rsp_zero
);

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             handshake;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sub;
  logic [ID_W-1:0]  op_id;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf, add_zero;

  // Round-robin pick: first valid requester after the last one served.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!grant_found && req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  // Next-state and grant decode; grants are suppressed while rst is high.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (grant_found && !rst) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign handshake = |(req_valid & req_ready);
  assign rsp_valid = (state == RESP);

  add_sub_arbiter_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a          (op_a),
    .b          (op_b),
    .invert_i_2 (op_sub),
    .sum        (add_sum),
    .overflow   (add_ovf),
    .zero       (add_zero)
  );

  // State, operand capture on grant, and result capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      op_a         <= '0;
      op_b         <= '0;
      op_sub       <= 1'b0;
      op_id        <= '0;
      rsp_o        <= '0;
      rsp_id       <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        last_grant <= grant_idx;
        op_id      <= grant_idx;
        op_a       <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
        op_b       <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
        op_sub     <= req_sub[grant_idx];
      end
      if (state == EXEC) begin
        rsp_o        <= add_sum;
        rsp_id       <= op_id;
        rsp_overflow <= add_ovf;
        rsp_zero     <= add_zero;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Directed and randomized checks of add_sub_arbiter against a behavioural model.
module tb_add_sub_arbiter;

  localparam int W = 32;
  localparam int N = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_o;
  logic           rsp_overflow, rsp_zero;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic         op_sub [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_cyc = 0;
  bit have_prev = 0;
  int model_last = N - 1;

  add_sub_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_o        (rsp_o),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_a   = '0;
    req_b   = '0;
    req_sub = '0;
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = op_a[k];
      req_b[k*W +: W] = op_b[k];
      req_sub[k]      = op_sub[k];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain signed arithmetic in 64 bits; overflow = true result out of 32-bit range.
  task automatic ref_calc(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                          output logic [W-1:0] o, output bit ov, output bit z);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    ov = (r > MAXV) || (r < MINV);
    o  = r[W-1:0];
    z  = (o == '0);
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask);
    for (int i = 1; i <= N; i++) begin
      if (mask[(model_last + i) % N]) return (model_last + i) % N;
    end
    return -1;
  endfunction

  // Entry/exit: #1 after a rising edge with the DUT idle.
  task automatic serve(input logic [N-1:0] mask, input int stall, input bit hold,
                       input bit gap, input string tag);
    logic [W-1:0] eo;
    bit           eov, ez;
    int           g;
    logic [N-1:0] eg;
    req_valid = mask;
    rsp_ready = (stall == 0);
    #1;
    g  = rr_pick(mask);
    eg = N'(1) << g;
    check({tag, " grant"}, 64'(req_ready), 64'(eg));
    if (gap && have_prev) check({tag, " issue gap"}, 64'(cyc - prev_cyc), 64'd3);
    prev_cyc   = cyc;
    have_prev  = 1;
    model_last = g;
    ref_calc(op_a[g], op_b[g], op_sub[g], eo, eov, ez);
    @(posedge clk); #1;
    if (!hold) req_valid = '0;
    check({tag, " exec valid"}, 64'(rsp_valid), 64'd0);
    check({tag, " exec ready"}, 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check({tag, " rsp valid"}, 64'(rsp_valid), 64'd1);
    check({tag, " rsp id"}, 64'(rsp_id), 64'(g));
    check({tag, " rsp o"}, 64'(rsp_o), 64'(eo));
    check({tag, " rsp ovf"}, 64'(rsp_overflow), 64'(eov));
    check({tag, " rsp zero"}, 64'(rsp_zero), 64'(ez));
    check({tag, " resp ready"}, 64'(req_ready), 64'd0);
    for (int s = 1; s <= stall; s++) begin
      @(posedge clk); #1;
      check({tag, " stall valid"}, 64'(rsp_valid), 64'd1);
      check({tag, " stall o"}, 64'(rsp_o), 64'(eo));
      check({tag, " stall id"}, 64'(rsp_id), 64'(g));
      check({tag, " stall flags"}, 64'({rsp_overflow, rsp_zero}), 64'({eov, ez}));
      check({tag, " stall ready"}, 64'(req_ready), 64'd0);
      if (s == stall) rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, " drop valid"}, 64'(rsp_valid), 64'd0);
    if (hold) begin
      eg = N'(1) << rr_pick(mask);
      check({tag, " idle regrant"}, 64'(req_ready), 64'(eg));
    end
    req_valid = '0;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("rst ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;
    check("rst valid", 64'(rsp_valid), 64'd0);
    check("rst o", 64'(rsp_o), 64'd0);
    check("rst id", 64'(rsp_id), 64'd0);
    check("rst flags", 64'({rsp_overflow, rsp_zero}), 64'd0);
    model_last = N - 1;
    have_prev  = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      op_a[k] = '0; op_b[k] = '0; op_sub[k] = 1'b0;
    end
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    reset_dut();

    op_a[0] = 32'd15; op_b[0] = 32'd39; op_sub[0] = 1'b1;
    serve(4'b0001, 0, 0, 0, "sub15_39");
    op_a[1] = 32'h7FFFFFFF; op_b[1] = 32'd1; op_sub[1] = 1'b0;
    serve(4'b0010, 0, 0, 0, "ovf_add");
    op_a[2] = 32'h80000000; op_b[2] = 32'd1; op_sub[2] = 1'b1;
    serve(4'b0100, 0, 0, 0, "ovf_sub");
    op_a[3] = 32'd210; op_b[3] = 32'd210; op_sub[3] = 1'b1;
    serve(4'b1000, 0, 0, 0, "zero_sub");
    op_a[0] = 32'd1; op_b[0] = 32'd0; op_sub[0] = 1'b1;
    serve(4'b0001, 0, 0, 0, "one_sub_zero");

    op_a[1] = $urandom; op_b[1] = $urandom; op_sub[1] = 1'b0;
    serve(4'b0110, 5, 1, 0, "backpressure");

    reset_dut();
    for (int k = 0; k < N; k++) begin
      op_a[k] = $urandom; op_b[k] = $urandom; op_sub[k] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 5; i++) serve(4'b1111, 0, 1, 1, "fair");

    op_a[2] = 32'd5; op_b[2] = 32'd3; op_sub[2] = 1'b0;
    req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    check("midrst grant", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    model_last = N - 1;
    have_prev  = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst no rsp", 64'(rsp_valid), 64'd0);
    end
    serve(4'b1111, 0, 0, 0, "after midrst");

    op_a[1] = 32'd9; op_b[1] = 32'd4; op_sub[1] = 1'b1;
    req_valid = 4'b0010; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    check("resprst pre valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    check("resprst valid", 64'(rsp_valid), 64'd0);
    check("resprst o", 64'(rsp_o), 64'd0);
    model_last = N - 1;
    have_prev  = 0;
    serve(4'b1010, 0, 0, 0, "after resprst");

    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < N; k++) begin
        op_a[k]   = $urandom;
        op_b[k]   = ($urandom_range(0, 3) == 0) ? op_a[k] : $urandom;
        op_sub[k] = 1'($urandom_range(0, 1));
      end
      serve(N'($urandom_range(1, 15)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
